// File: rtl/gg_vlc_bit_packer_pkg.sv
// Shared types and constants for the VLC bit packer: codeword bundle, packer FSM states,
// and the codeword legality rule.
package gg_vlc_bit_packer_pkg;

  localparam int PAD_BITS = 32;

  typedef struct packed {
    logic [31:0] code;
    logic [5:0]  len;
    logic        mb_start;
    logic        flush;
  } vlc_t;

  typedef enum logic [0:0] {
    PK_RUN   = 1'b0,
    PK_FLUSH = 1'b1
  } pack_state_e;

  // A zero-length codeword is only meaningful as a pure end-of-stream marker.
  function automatic logic len_legal(input logic [5:0] len, input logic flush);
    return (len <= 6'd32) && ((len != 6'd0) || flush);
  endfunction

endpackage

// File: rtl/gg_vlc_bit_packer_if.sv
// Codeword-in / packed-word-out bundle of the VLC bit packer.
// master: codeword producer and word consumer; slave: the packer itself.
interface gg_vlc_bit_packer_if #(parameter int WID = 32);

  logic           in_valid;
  logic           in_ready;
  logic [31:0]    in_code;
  logic [5:0]     in_len;
  logic           in_mb_start;
  logic           in_flush;

  logic           out_valid;
  logic           out_ready;
  logic [WID-1:0] out_bits;
  logic [31:0]    out_pad;
  logic [WID-1:0] out_mb_start;
  logic           out_last;

  modport master (
    output in_valid, in_code, in_len, in_mb_start, in_flush, out_ready,
    input  in_ready, out_valid, out_bits, out_pad, out_mb_start, out_last
  );

  modport slave (
    input  in_valid, in_code, in_len, in_mb_start, in_flush, out_ready,
    output in_ready, out_valid, out_bits, out_pad, out_mb_start, out_last
  );

endinterface

// File: rtl/gg_vlc_bit_insert.sv
// Left-aligned barrel insert: places a right-justified codeword of len bits at an MSB-first
// offset inside an ACCW-bit field, plus a one-hot marker at the codeword's first bit.
module gg_bit_insert #(
  parameter int WID = 32
) (
  input  logic [31:0]            code,
  input  logic [5:0]             len,
  input  logic                   mb_start,
  input  logic [$clog2(WID+65)-1:0] offset,
  output logic [WID+63:0]        ins_bits,
  output logic [WID+63:0]        ins_mk
);

  localparam int ACCW = WID + 64;
  localparam logic [ACCW-1:0] TOP_BIT_S = {1'b1, {(ACCW-1){1'b0}}};

  logic [5:0]  lsh_s;
  logic [31:0] code_la_s;

  // Left-justify the code (dropping bits above len), then shift it down to the fill point.
  always_comb begin
    lsh_s     = 6'd32 - len;
    code_la_s = code << lsh_s;
    ins_bits  = {code_la_s, {(ACCW-32){1'b0}}} >> offset;
    if (mb_start && (len != 6'd0)) begin
      ins_mk = TOP_BIT_S >> offset;
    end else begin
      ins_mk = '0;
    end
  end

endmodule

// File: rtl/gg_vlc_bit_packer_chk.sv
// Simulation checker for the packer input contract.
module gg_vlc_bit_packer_chk (
  input logic       clk,
  input logic       reset,
  input logic       in_valid,
  input logic       in_ready,
  input logic [5:0] in_len,
  input logic       in_flush
);

  a_len_legal: assert property (
    @(posedge clk) disable iff (!reset)
    (in_valid && in_ready) |-> ((in_len <= 6'd32) && ((in_len != 6'd0) || in_flush))
  );

endmodule

// File: rtl/gg_vlc_bit_packer.sv
// Encoder bitstream writer: packs 1..32-bit codewords MSB-first into WID-bit words, each with
// a 32-bit lookahead pad and an aligned macroblock-start marker.
module gg_vlc_bit_packer
  import gg_vlc_bit_packer_pkg::*;
#(
  parameter int WID = 32
) (
  input logic                clk,
  input logic                reset,
  gg_vlc_bit_packer_if.slave bus
);

  localparam int ACCW = WID + 64;
  localparam int FW   = $clog2(ACCW + 1);
  localparam logic [FW-1:0] FILL_WID  = FW'(WID);
  localparam logic [FW-1:0] FILL_FULL = FW'(WID + PAD_BITS);

  pack_state_e     state_r, state_s;
  logic [ACCW-1:0] acc_r, acc_s, acc_pop_s;
  logic [ACCW-1:0] mk_r, mk_s, mk_pop_s;
  logic [ACCW-1:0] ins_bits_s, ins_mk_s;
  logic [FW-1:0]   fill_r, fill_s, base_fill_s;
  logic            in_ready_r, out_valid_r, out_last_r;
  logic            in_ready_s, out_valid_s, out_last_s;
  logic            push_s, pop_s;
  vlc_t            vlc_s;

  assign vlc_s = '{code: bus.in_code, len: bus.in_len, mb_start: bus.in_mb_start,
                   flush: bus.in_flush};

  // Handshakes and the post-pop view of the accumulator that a same-cycle push lands in.
  always_comb begin
    pop_s  = out_valid_r && bus.out_ready;
    push_s = bus.in_valid && in_ready_r && len_legal(vlc_s.len, vlc_s.flush);
    if (pop_s) begin
      acc_pop_s = acc_r << WID;
      mk_pop_s  = mk_r << WID;
      if (fill_r > FILL_WID) begin
        base_fill_s = fill_r - FILL_WID;
      end else begin
        base_fill_s = '0;
      end
    end else begin
      acc_pop_s   = acc_r;
      mk_pop_s    = mk_r;
      base_fill_s = fill_r;
    end
  end

  gg_bit_insert #(.WID(WID)) u_insert (
    .code     (vlc_s.code),
    .len      (vlc_s.len),
    .mb_start (vlc_s.mb_start),
    .offset   (base_fill_s),
    .ins_bits (ins_bits_s),
    .ins_mk   (ins_mk_s)
  );

  // Next accumulator/fill/state; handshake flags are derived from next state so they leave a flop.
  always_comb begin
    if (push_s) begin
      acc_s  = acc_pop_s | ins_bits_s;
      mk_s   = mk_pop_s | ins_mk_s;
      fill_s = base_fill_s + FW'(vlc_s.len);
    end else begin
      acc_s  = acc_pop_s;
      mk_s   = mk_pop_s;
      fill_s = base_fill_s;
    end
    case (state_r)
      PK_RUN: begin
        if (push_s && vlc_s.flush && (fill_s != '0)) begin
          state_s = PK_FLUSH;
        end else begin
          state_s = PK_RUN;
        end
      end
      PK_FLUSH: begin
        if (pop_s && out_last_r) begin
          state_s = PK_RUN;
          fill_s  = '0;
        end else begin
          state_s = PK_FLUSH;
        end
      end
      default: state_s = PK_RUN;
    endcase
    in_ready_s = (state_s == PK_RUN) && (fill_s <= FILL_FULL);
    if (state_s == PK_FLUSH) begin
      out_valid_s = (fill_s != '0);
      out_last_s  = (fill_s <= FILL_WID);
    end else begin
      out_valid_s = (fill_s >= FILL_FULL);
      out_last_s  = 1'b0;
    end
  end

  // State registers; reset drops any buffered bits without emitting a partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= PK_RUN;
      acc_r       <= '0;
      mk_r        <= '0;
      fill_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      mk_r        <= mk_s;
      fill_r      <= fill_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
    end
  end

  assign bus.in_ready     = in_ready_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_last     = out_last_r;
  assign bus.out_bits     = acc_r[ACCW-1 -: WID];
  assign bus.out_pad      = acc_r[ACCW-1-WID -: PAD_BITS];
  assign bus.out_mb_start = mk_r[ACCW-1 -: WID];

  gg_vlc_bit_packer_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .in_valid (bus.in_valid),
    .in_ready (in_ready_r),
    .in_len   (bus.in_len),
    .in_flush (bus.in_flush)
  );

endmodule

// File: tb/tb_gg_vlc_bit_packer.sv
// Self-checking bench for gg_vlc_bit_packer (WID=32): a bit-level stream queue predicts every
// emitted word, pad, marker and last flag; scenario tasks add targeted checks.
module tb_gg_vlc_bit_packer;
  import gg_vlc_bit_packer_pkg::*;

  localparam int WID = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  gg_vlc_bit_packer_if #(.WID(WID)) bus();

  gg_vlc_bit_packer #(.WID(WID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard: stream bits in order, with a parallel first-bit-of-macroblock flag.
  bit sb_bits[$];
  bit sb_mk[$];
  bit sb_flushed;
  logic [WID-1:0] obs_bits[$];
  logic [31:0]    obs_pad[$];
  logic [WID-1:0] obs_mk[$];
  logic           obs_last[$];

  logic [WID-1:0] m_bits, m_mk;
  logic [31:0]    m_pad;
  logic           m_last, m_exp_ready, m_exp_valid;

  // Monitor: sample away from the active edge, check, then apply the transfers of the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      sb_bits.delete();
      sb_mk.delete();
      sb_flushed = 1'b0;
    end else begin
      m_exp_ready = !sb_flushed && (sb_bits.size() <= WID + 32);
      m_exp_valid = sb_flushed ? (sb_bits.size() > 0) : (sb_bits.size() >= WID + 32);
      checks++;
      if (bus.in_ready !== m_exp_ready || bus.out_valid !== m_exp_valid) begin
        errors++;
        $display("FAIL handshake @%0t: in_ready=%b out_valid=%b, expected in_ready=%b out_valid=%b",
                 $time, bus.in_ready, bus.out_valid, m_exp_ready, m_exp_valid);
      end
      if (bus.out_valid && bus.out_ready) begin
        for (int i = 0; i < WID; i++) begin
          m_bits[WID-1-i] = (i < sb_bits.size()) ? sb_bits[i] : 1'b0;
          m_mk[WID-1-i]   = (i < sb_mk.size()) ? sb_mk[i] : 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
          m_pad[31-i] = (WID + i < sb_bits.size()) ? sb_bits[WID+i] : 1'b0;
        end
        m_last = sb_flushed && (sb_bits.size() <= WID);
        checks++;
        if (bus.out_bits !== m_bits || bus.out_pad !== m_pad || bus.out_mb_start !== m_mk ||
            bus.out_last !== m_last) begin
          errors++;
          $display("FAIL word @%0t: bits=%h pad=%h mk=%h last=%b, expected bits=%h pad=%h mk=%h last=%b",
                   $time, bus.out_bits, bus.out_pad, bus.out_mb_start, bus.out_last,
                   m_bits, m_pad, m_mk, m_last);
        end
        obs_bits.push_back(bus.out_bits);
        obs_pad.push_back(bus.out_pad);
        obs_mk.push_back(bus.out_mb_start);
        obs_last.push_back(bus.out_last);
        for (int i = 0; i < WID; i++) begin
          if (sb_bits.size() > 0) begin
            void'(sb_bits.pop_front());
            void'(sb_mk.pop_front());
          end
        end
        if (m_last) sb_flushed = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        for (int i = int'(bus.in_len) - 1; i >= 0; i--) begin
          sb_bits.push_back(bus.in_code[i]);
          sb_mk.push_back(bus.in_mb_start && (i == int'(bus.in_len) - 1));
        end
        if (bus.in_flush && sb_bits.size() > 0) sb_flushed = 1'b1;
      end
    end
  end

  task automatic send_code(input logic [31:0] code, input logic [5:0] len,
                           input logic mb, input logic fl);
    int n;
    n = 0;
    bus.in_valid    = 1'b1;
    bus.in_code     = code;
    bus.in_len      = len;
    bus.in_mb_start = mb;
    bus.in_flush    = fl;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_bits.size() != 0 || sb_flushed) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_bits.size() != 0 || sb_flushed) begin
      errors++;
      $display("FAIL drain_timeout: %0d bits still buffered, required 0", sb_bits.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_bits !== '0 ||
          bus.out_pad !== '0 || bus.out_mb_start !== '0 || bus.out_last !== 1'b0) begin
        errors++;
        $display("FAIL reset_state%0d: in_ready=%b out_valid=%b bits=%h pad=%h mk=%h last=%b, required 1 0 0 0 0 0",
                 k, bus.in_ready, bus.out_valid, bus.out_bits, bus.out_pad, bus.out_mb_start,
                 bus.out_last);
      end
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ones_fill();
    obs_bits.delete(); obs_pad.delete(); obs_mk.delete(); obs_last.delete();
    for (int i = 0; i < 63; i++) send_code(32'h0000_0001, 6'd1, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ones_early: out_valid=%b at fill 63, required 0", bus.out_valid);
    end
    send_code(32'h0000_0001, 6'd1, 1'b0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_bits !== 32'hFFFF_FFFF || bus.out_pad !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL ones_full: out_valid=%b bits=%h pad=%h, required 1 ffffffff ffffffff",
               bus.out_valid, bus.out_bits, bus.out_pad);
    end
    send_code(32'h0, 6'd0, 1'b0, 1'b1);
    wait_drain();
    checks++;
    if (obs_last.size() != 2 || obs_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL ones_words: %0d words, required 2 ending with last", obs_last.size());
    end
  endtask

  task automatic test_mb_vector();
    logic [127:0] vec_v;
    logic [127:0] tmp_v;
    logic [31:0]  mask_v, code_v, exp_pad_v;
    int lens[10] = '{5, 13, 1, 32, 7, 20, 3, 11, 17, 19};
    int consumed;
    vec_v = 128'hC3A5_1E7F_0B92_D64E_8F10_2B7C_E549_A6D3;
    consumed = 0;
    obs_bits.delete(); obs_pad.delete(); obs_mk.delete(); obs_last.delete();
    for (int k = 0; k < 10; k++) begin
      tmp_v  = vec_v >> (128 - consumed - lens[k]);
      mask_v = (lens[k] == 32) ? 32'hFFFF_FFFF : ((32'h1 << lens[k]) - 32'h1);
      code_v = (tmp_v[31:0] & mask_v) | (32'h5A5A_C3C3 & ~mask_v);
      send_code(code_v, 6'(lens[k]), (k == 0), (k == 9));
      consumed += lens[k];
    end
    wait_drain();
    checks++;
    if (obs_bits.size() != 4) begin
      errors++;
      $display("FAIL mb_count: %0d words, required 4", obs_bits.size());
    end else begin
      for (int w = 0; w < 4; w++) begin
        if (w < 3) exp_pad_v = vec_v[95-32*w -: 32];
        else exp_pad_v = 32'h0;
        checks++;
        if (obs_bits[w] !== vec_v[127-32*w -: 32] || obs_pad[w] !== exp_pad_v ||
            obs_mk[w] !== ((w == 0) ? 32'h8000_0000 : 32'h0) || obs_last[w] !== (w == 3)) begin
          errors++;
          $display("FAIL mb_word%0d: bits=%h pad=%h mk=%h last=%b, required bits=%h pad=%h",
                   w, obs_bits[w], obs_pad[w], obs_mk[w], obs_last[w],
                   vec_v[127-32*w -: 32], exp_pad_v);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WID-1:0] s_bits, s_mk;
    logic [31:0]    s_pad;
    logic           held, acc_now;
    int accepted, total, len_r;
    obs_bits.delete(); obs_pad.delete(); obs_mk.delete(); obs_last.delete();
    bus.out_ready = 1'b0;
    held = 1'b0;
    accepted = 0;
    s_bits = '0; s_mk = '0; s_pad = '0;
    bus.in_valid = 1'b1; bus.in_code = $urandom(); bus.in_len = 6'd32;
    bus.in_mb_start = 1'b0; bus.in_flush = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc_now = bus.in_ready;
      if (bus.out_valid) begin
        if (!held) begin
          held = 1'b1;
          s_bits = bus.out_bits; s_pad = bus.out_pad; s_mk = bus.out_mb_start;
        end else begin
          checks++;
          if (bus.out_bits !== s_bits || bus.out_pad !== s_pad || bus.out_mb_start !== s_mk) begin
            errors++;
            $display("FAIL bp_hold: bits=%h pad=%h, required stable %h %h",
                     bus.out_bits, bus.out_pad, s_bits, s_pad);
          end
        end
      end
      @(posedge clk);
      #1;
      if (acc_now) begin
        accepted++;
        bus.in_code = $urandom();
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (accepted != 3 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: accepted=%0d in_ready=%b, required 3 and 0", accepted, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    total = 96;
    for (int k = 0; k < 6; k++) begin
      len_r = $urandom_range(1, 32);
      total += len_r;
      send_code($urandom(), 6'(len_r), 1'($urandom_range(0, 1)), (k == 5));
    end
    wait_drain();
    checks++;
    if (obs_bits.size() != (total + 31) / 32) begin
      errors++;
      $display("FAIL bp_count: %0d words, required %0d", obs_bits.size(), (total + 31) / 32);
    end
  endtask

  task automatic test_flush_partial();
    obs_bits.delete(); obs_pad.delete(); obs_mk.delete(); obs_last.delete();
    send_code(32'h0000_0005, 6'd3, 1'b0, 1'b1);
    wait_drain();
    checks++;
    if (obs_bits.size() != 1 || obs_bits[0] !== 32'hA000_0000 || obs_pad[0] !== 32'h0 ||
        obs_last[0] !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_partial: words=%0d in_ready=%b, required 1 word a0000000/0/last and in_ready 1",
               obs_bits.size(), bus.in_ready);
    end
    send_code(32'h0, 6'd0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_bits.size() != 1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: words=%0d out_valid=%b in_ready=%b, required 1 0 1",
               obs_bits.size(), bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstream();
    obs_bits.delete(); obs_pad.delete(); obs_mk.delete(); obs_last.delete();
    bus.out_ready = 1'b0;
    send_code($urandom(), 6'd32, 1'b1, 1'b0);
    send_code($urandom(), 6'd32, 1'b0, 1'b0);
    send_code($urandom(), 6'd16, 1'b0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_flush: out_valid=%b in_ready=%b, required 1 0", bus.out_valid, bus.in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_bits !== '0 || bus.out_pad !== '0 ||
        bus.out_mb_start !== '0 || bus.out_last !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b bits=%h pad=%h mk=%h last=%b in_ready=%b, required all zero and in_ready 1",
               bus.out_valid, bus.out_bits, bus.out_pad, bus.out_mb_start, bus.out_last, bus.in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    send_code(32'hFFFF_DEAD, 6'd16, 1'b1, 1'b1);
    wait_drain();
    checks++;
    if (obs_bits.size() != 1 || obs_bits[0] !== 32'hDEAD_0000 || obs_mk[0] !== 32'h8000_0000 ||
        obs_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_restart: words=%0d, required 1 word dead0000 with marker bit 31 and last",
               obs_bits.size());
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_code = 32'h0; bus.in_len = 6'd0;
    bus.in_mb_start = 1'b0; bus.in_flush = 1'b0; bus.out_ready = 1'b1;
    sb_flushed = 1'b0;
    test_reset();
    test_ones_fill();
    test_mb_vector();
    test_backpressure();
    test_flush_partial();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
